// File: rtl/bus_map_pkg.sv
// rtl/bus_map_pkg.sv - shared state enum, default slave map and slave indices for bus_write_router
package bus_map_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } wr_state_e;

    localparam int SLV_MEM   = 0;
    localparam int SLV_UART  = 1;
    localparam int SLV_GAUSS = 2;
    localparam int SLV_LEDS  = 3;
    localparam int SLV_7SEG  = 4;

    // Slave 0 occupies the least-significant 16-bit slice.
    localparam logic [79:0] DEF_SLV_BASE = {16'h2008, 16'h2004, 16'h2030, 16'h2010, 16'h1000};
    localparam logic [79:0] DEF_SLV_MASK = {16'hF00F, 16'hF00F, 16'hF0F0, 16'hF0F0, 16'hF000};

endpackage

// File: rtl/addr_region_match.sv
// rtl/addr_region_match.sv - parallel base/mask region compare with lowest-index priority select
module addr_region_match #(
    parameter int                     N_SLV    = 5,
    parameter int                     DEC_W    = 16,
    parameter logic [N_SLV*DEC_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*DEC_W-1:0] SLV_MASK = '0
) (
    input  logic [DEC_W-1:0] addr,
    output logic [N_SLV-1:0] sel_oh,
    output logic             any_hit
);

    logic [N_SLV-1:0] hit;

    // One masked compare per region; a 1 in the mask means the bit takes part.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_SLV; i++) begin
            hit[i] = ((addr & SLV_MASK[i*DEC_W +: DEC_W]) ==
                      (SLV_BASE[i*DEC_W +: DEC_W] & SLV_MASK[i*DEC_W +: DEC_W]));
        end
    end

    // Isolating the lowest set bit gives the lowest-index-wins priority on overlap.
    assign sel_oh  = hit & (~hit + N_SLV'(1));
    assign any_hit = |hit;

endmodule

// File: rtl/bus_write_router.sv
// rtl/bus_write_router.sv - store decoder with one-entry write buffer, req/ack handshake and sticky error (optional BUS_WR_PERF_CNT_EN counters)
module bus_write_router
    import bus_map_pkg::*;
#(
    parameter int                     N_SLV    = 5,
    parameter int                     DATA_W   = 32,
    parameter int                     DEC_W    = 16,
    parameter logic [N_SLV*DEC_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*DEC_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic                we_i,
    output logic                stall_o,
    output logic [N_SLV-1:0]    req_o,
    input  logic [N_SLV-1:0]    ack_i,
    output logic [DEC_W-1:0]    waddr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] be_o,
    output logic                err_o,
    output logic [31:0]         err_addr_o,
    input  logic                err_clr_i
`ifdef BUS_WR_PERF_CNT_EN
    ,
    output logic [N_SLV*16-1:0] wr_cnt_o
`endif
);

    wr_state_e        state_q, state_d;
    logic [N_SLV-1:0] sel_oh;
    logic             any_hit;
    logic             store_go;
    logic             miss;
    logic             handshake;

    addr_region_match #(
        .N_SLV    (N_SLV),
        .DEC_W    (DEC_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .addr    (addr_i[DEC_W-1:0]),
        .sel_oh  (sel_oh),
        .any_hit (any_hit)
    );

    // Next state: accept a mapped store from IDLE, leave PEND on the selected slave's ack.
    always_comb begin
        state_d   = state_q;
        store_go  = 1'b0;
        miss      = 1'b0;
        handshake = |(req_o & ack_i);
        case (state_q)
            IDLE: begin
                if (we_i) begin
                    if (any_hit) begin
                        store_go = 1'b1;
                        state_d  = PEND;
                    end else begin
                        miss = 1'b1;
                    end
                end
            end
            PEND: begin
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_o = (state_q == PEND);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write buffer and request: captured on accept, held through PEND, request dropped on ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_o   <= '0;
            waddr_o <= '0;
            wdata_o <= '0;
            be_o    <= '0;
        end else if (store_go) begin
            req_o   <= sel_oh;
            waddr_o <= addr_i[DEC_W-1:0];
            wdata_o <= wdata_i;
            be_o    <= be_i;
        end else if (handshake) begin
            req_o   <= '0;
        end
    end

    // Sticky error keeps the first unmapped address; a new miss beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (miss && (!err_o || err_clr_i)) begin
            err_o      <= 1'b1;
            err_addr_o <= addr_i;
        end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end
    end

`ifdef BUS_WR_PERF_CNT_EN
    for (genvar i = 0; i < N_SLV; i++) begin : g_cnt
        logic [15:0] cnt_q;

        // Saturating count of completed handshakes for this slave.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (err_clr_i) begin
                cnt_q <= '0;
            end else if (req_o[i] && ack_i[i] && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign wr_cnt_o[i*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_bus_write_router.sv
// tb/tb_bus_write_router.sv - self-checking bench for bus_write_router with a behavioural reference model
module tb_bus_write_router;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [4:0]  ack;
    logic        clr;

    logic        stall_o;
    logic [4:0]  req_o;
    logic [15:0] waddr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        err_o;
    logic [31:0] err_addr_o;

    logic [1:0]  ovl_ack;
    logic        ovl_stall;
    logic [1:0]  ovl_req;
    logic [15:0] ovl_waddr;
    logic [31:0] ovl_wdata;
    logic [3:0]  ovl_be;
    logic        ovl_err;
    logic [31:0] ovl_err_addr;

`ifdef BUS_WR_PERF_CNT_EN
    logic [79:0] wr_cnt_o;
    logic [31:0] ovl_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic        m_pend;
    int          m_sel;
    logic [15:0] m_waddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_err;
    logic [31:0] m_eaddr;
    int          m_cnt[5];

    logic [15:0] reg_base[5] = '{16'h1000, 16'h2010, 16'h2030, 16'h2004, 16'h2008};
    logic [15:0] reg_mask[5] = '{16'hF000, 16'hF0F0, 16'hF0F0, 16'hF00F, 16'hF00F};

    bus_write_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .be_i       (be),
        .we_i       (we),
        .stall_o    (stall_o),
        .req_o      (req_o),
        .ack_i      (ack),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .be_o       (be_o),
        .err_o      (err_o),
        .err_addr_o (err_addr_o),
        .err_clr_i  (clr)
`ifdef BUS_WR_PERF_CNT_EN
        ,
        .wr_cnt_o   (wr_cnt_o)
`endif
    );

    bus_write_router #(
        .N_SLV    (2),
        .SLV_BASE ({16'h2000, 16'h2000}),
        .SLV_MASK ({16'hF000, 16'hF000})
    ) u_ovl (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .be_i       (be),
        .we_i       (we),
        .stall_o    (ovl_stall),
        .req_o      (ovl_req),
        .ack_i      (ovl_ack),
        .waddr_o    (ovl_waddr),
        .wdata_o    (ovl_wdata),
        .be_o       (ovl_be),
        .err_o      (ovl_err),
        .err_addr_o (ovl_err_addr),
        .err_clr_i  (clr)
`ifdef BUS_WR_PERF_CNT_EN
        ,
        .wr_cnt_o   (ovl_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_hit(input logic [15:0] a);
        for (int i = 0; i < 5; i++) begin
            if ((a & reg_mask[i]) == (reg_base[i] & reg_mask[i])) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_sel = 0; m_waddr = '0; m_wdata = '0; m_be = '0;
        m_err = 1'b0; m_eaddr = '0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  k;
        logic unm;
        unm = 1'b0;
        if (!m_pend) begin
            if (we) begin
                k = first_hit(addr[15:0]);
                if (k >= 0) begin
                    m_pend = 1'b1; m_sel = k;
                    m_waddr = addr[15:0]; m_wdata = wdata; m_be = be;
                end else begin
                    unm = 1'b1;
                end
            end
        end else if (ack[m_sel]) begin
            m_pend = 1'b0;
            if (!clr && m_cnt[m_sel] < 65535) m_cnt[m_sel]++;
        end
        if (clr) for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        if (unm && (!m_err || clr)) begin
            m_err = 1'b1; m_eaddr = addr;
        end else if (clr) begin
            m_err = 1'b0; m_eaddr = '0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":req"},   64'(req_o),      m_pend ? (64'd1 << m_sel) : 64'd0);
        chk({tag, ":stall"}, 64'(stall_o),    64'(m_pend));
        chk({tag, ":waddr"}, 64'(waddr_o),    64'(m_waddr));
        chk({tag, ":wdata"}, 64'(wdata_o),    64'(m_wdata));
        chk({tag, ":be"},    64'(be_o),       64'(m_be));
        chk({tag, ":err"},   64'(err_o),      64'(m_err));
        chk({tag, ":eaddr"}, 64'(err_addr_o), 64'(m_eaddr));
`ifdef BUS_WR_PERF_CNT_EN
        for (int i = 0; i < 5; i++) chk({tag, ":cnt"}, 64'(wr_cnt_o[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [4:0] ak, input logic c, input string tag);
        we = w; addr = a; wdata = d; be = b; ack = ak; clr = c;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] r;
        int          idx;
        logic [15:0] pick[11] = '{16'h1000, 16'h1ABC, 16'h2010, 16'h2F1F, 16'h2030, 16'h2004,
                                  16'h2F08, 16'h2008, 16'h3000, 16'h4000, 16'h2000};

        rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; ack = '0; clr = 1'b0;
        ovl_ack = 2'b11;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Overlapping regions: lowest index wins.
        step(1'b1, 32'h0000_2000, 32'h1, 4'hF, 5'b11111, 1'b0, "ovl_store");
        chk("ovl_req", 64'(ovl_req), 64'd1);
        step(1'b0, 32'h0, 32'h0, 4'h0, 5'b11111, 1'b1, "ovl_clr");

        // Zero-wait slave.
        step(1'b1, 32'h0000_1040, 32'hDEAD_BEEF, 4'hF, 5'b11111, 1'b0, "t1_store");
        chk("t1_req",   64'(req_o),   64'h01);
        chk("t1_wdata", 64'(wdata_o), 64'hDEAD_BEEF);
        chk("t1_waddr", 64'(waddr_o), 64'h1040);
        step(1'b0, 32'h0, 32'h0, 4'h0, 5'b11111, 1'b0, "t1_done");
        chk("t1_stall_drop", 64'(stall_o), 64'd0);

        // Slave 1 with three wait states.
        step(1'b1, 32'h0000_2010, 32'h1234_5678, 4'h3, 5'b11101, 1'b0, "t2_store");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_2010, 32'h1234_5678, 4'h3, 5'b11101, 1'b0, "t2_wait");
            chk("t2_req_held", 64'(req_o), 64'h02);
        end
        step(1'b1, 32'h0000_2010, 32'h1234_5678, 4'h3, 5'b11111, 1'b0, "t2_ack");
        chk("t2_req_drop", 64'(req_o), 64'd0);

        // Unmapped stores and clear.
        step(1'b1, 32'h0000_3000, 32'h0, 4'hF, 5'b11111, 1'b0, "t3_miss1");
        chk("t3_eaddr1", 64'(err_addr_o), 64'h3000);
        step(1'b1, 32'h0000_4000, 32'h0, 4'hF, 5'b11111, 1'b0, "t3_miss2");
        chk("t3_eaddr2", 64'(err_addr_o), 64'h3000);
        step(1'b0, 32'h0, 32'h0, 4'h0, 5'b11111, 1'b1, "t3_clr");
        chk("t3_err_clr", 64'(err_o), 64'd0);

        // Reset while pending on slave 4.
        step(1'b1, 32'h0000_2008, 32'hCAFE_0000, 4'hF, 5'b00000, 1'b0, "t4_store");
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_req",   64'(req_o),   64'd0);
        chk("t4_rst_stall", 64'(stall_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h0000_2004, 32'h5555_AAAA, 4'h5, 5'b11111, 1'b0, "t4_new");
        chk("t4_new_req", 64'(req_o), 64'h08);
        step(1'b0, 32'h0, 32'h0, 4'h0, 5'b11111, 1'b0, "t4_idle");

`ifdef BUS_WR_PERF_CNT_EN
        step(1'b0, 32'h0, 32'h0, 4'h0, 5'b11111, 1'b1, "pc_clr");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_1000, 32'h0, 4'hF, 5'b11111, 1'b0, "pc_mem");
            step(1'b0, 32'h0, 32'h0, 4'h0, 5'b11111, 1'b0, "pc_idle");
        end
        step(1'b1, 32'h0000_2004, 32'h0, 4'hF, 5'b11111, 1'b0, "pc_leds");
        step(1'b0, 32'h0, 32'h0, 4'h0, 5'b11111, 1'b0, "pc_idle");
        chk("pc_mem_cnt",  64'(wr_cnt_o[15:0]),  64'd3);
        chk("pc_leds_cnt", 64'(wr_cnt_o[63:48]), 64'd1);
        chk("pc_uart_cnt", 64'(wr_cnt_o[31:16]), 64'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r   = $urandom();
            idx = $urandom_range(0, 11);
            if (idx == 11) addr = r;
            else           addr = {r[31:16], pick[idx]};
            step($urandom_range(0, 3) != 0, addr, $urandom(), 4'($urandom()), 5'($urandom()),
                 $urandom_range(0, 15) == 0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
